// File: rtl/occupancy_counter_mc_pkg.sv
// Shared defaults and the count-width helper for the multi-door occupancy counter.
package occ_pkg;

    localparam int OCC_MAX_DEF   = 20;
    localparam int OCC_DEB_DEF   = 3;
    localparam int OCC_DOORS_DEF = 2;

    function automatic int occ_cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/occupancy_counter_mc_pad_debounce.sv
// One pressure pad: two-flop synchroniser, level debouncer and rising-edge event.
module pad_debounce
    import occ_pkg::*;
#(
    parameter int DEBOUNCE_CYC = OCC_DEB_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // The level flips on the DEBOUNCE_CYC-th consecutive differing sample.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/occupancy_counter_mc.sv
// Multi-door saturating store occupancy counter; define OCC_PEAK_EN to add the peak-hold output.
module occupancy_counter_mc
    import occ_pkg::*;
#(
    parameter int N_DOORS      = OCC_DOORS_DEF,
    parameter int MAX_OCC      = OCC_MAX_DEF,
    parameter int DEBOUNCE_CYC = OCC_DEB_DEF,
    localparam int CNT_W       = occ_cnt_w(MAX_OCC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_DOORS-1:0] pressure_in,
    input  logic [N_DOORS-1:0] pressure_out,
    input  logic               clr,
    input  logic               clr_err,
`ifdef OCC_PEAK_EN
    input  logic               peak_clr,
    output logic [CNT_W-1:0]   peak,
`endif
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               entry_en,
    output logic               err_ovf,
    output logic               err_unf
);

    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_OCC);

    logic [N_DOORS-1:0] in_level, in_rise, out_level, out_rise;
    logic [N_DOORS-1:0] in_evt, out_evt;

    for (genvar d = 0; d < N_DOORS; d++) begin : g_pad
        pad_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_in (
            .clk(clk), .reset_n(reset_n), .raw(pressure_in[d]),
            .level(in_level[d]), .rise(in_rise[d])
        );
        pad_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_out (
            .clk(clk), .reset_n(reset_n), .raw(pressure_out[d]),
            .level(out_level[d]), .rise(out_rise[d])
        );
    end

    assign in_evt  = in_rise & in_level;
    assign out_evt = out_rise & out_level;

    logic signed [SW-1:0] e_sum, x_sum, next_val;
    logic                 ovf_now, unf_now;

    always_comb begin
        e_sum = '0;
        x_sum = '0;
        for (int d = 0; d < N_DOORS; d++) begin
            e_sum = e_sum + {{(SW-1){1'b0}}, in_evt[d]};
            x_sum = x_sum + {{(SW-1){1'b0}}, out_evt[d]};
        end
        // Entries and exits net out before saturation is applied.
        next_val = $signed({2'b00, count}) + e_sum - x_sum;
        ovf_now  = !clr && (next_val > MAX_S);
        unf_now  = !clr && next_val[SW-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (clr)          count <= '0;
            else if (ovf_now) count <= CNT_W'(MAX_OCC);
            else if (unf_now) count <= '0;
            else              count <= next_val[CNT_W-1:0];
            err_ovf <= ovf_now | (err_ovf & ~clr_err);
            err_unf <= unf_now | (err_unf & ~clr_err);
        end
    end

    assign full     = (count == CNT_W'(MAX_OCC));
    assign empty    = (count == '0);
    assign entry_en = ~full;

`ifdef OCC_PEAK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          peak <= '0;
        else if (peak_clr)     peak <= count;
        else if (count > peak) peak <= count;
    end
`endif

endmodule

// File: tb/tb_occupancy_counter_mc.sv
// Directed bench for occupancy_counter_mc at default parameters (peak checks when OCC_PEAK_EN is defined).
module tb_occupancy_counter_mc;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] pressure_in;
    logic [1:0] pressure_out;
    logic       clr;
    logic       clr_err;
    logic [4:0] count;
    logic       full, empty, entry_en, err_ovf, err_unf;
`ifdef OCC_PEAK_EN
    logic       peak_clr;
    logic [4:0] peak;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    occupancy_counter_mc dut (
        .clk(clk), .reset_n(reset_n),
        .pressure_in(pressure_in), .pressure_out(pressure_out),
        .clr(clr), .clr_err(clr_err),
`ifdef OCC_PEAK_EN
        .peak_clr(peak_clr), .peak(peak),
`endif
        .count(count), .full(full), .empty(empty), .entry_en(entry_en),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [4:0] c, input logic f, input logic e,
                               input logic ov, input logic un);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".flags"}, {28'd0, full, empty, entry_en, 1'b0},
              {28'd0, f, e, ~f, 1'b0});
        check({tag, ".errs"}, {30'd0, err_ovf, err_unf}, {30'd0, ov, un});
    endtask

    // Hold the pads long enough to register one event each, then settle the release.
    task automatic press(input logic [1:0] in_mask, input logic [1:0] out_mask);
        pressure_in  = in_mask;
        pressure_out = out_mask;
        repeat (6) tick();
        pressure_in  = '0;
        pressure_out = '0;
        repeat (6) tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; pressure_in = '0; pressure_out = '0; clr = 1'b0; clr_err = 1'b0;
`ifdef OCC_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (3) tick();
        check_flags("reset", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single entry: count changes exactly 5 edges after the first high sample.
        pressure_in = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("latency_hold", 32'(count), 32'd0);
        end
        tick();
        check_flags("first_entry", 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        pressure_in = '0;
        repeat (10) tick();
        check("single_event", 32'(count), 32'd1);

        // Two-sample glitch is filtered.
        pressure_in = 2'b10;
        repeat (2) tick();
        pressure_in = '0;
        repeat (10) tick();
        check("glitch", 32'(count), 32'd1);
        do_clr();
        check_flags("clr", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Fill to capacity with paired entries.
        for (int i = 1; i <= 10; i++) begin
            press(2'b11, 2'b00);
            check("fill", 32'(count), 32'(2 * i));
        end
        check_flags("full", 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
        press(2'b01, 2'b00);
        check_flags("overflow", 5'd20, 1'b1, 1'b0, 1'b1, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_flags("clr_err", 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);

        // Entry and exit in the same cycle at capacity cancel.
        press(2'b01, 2'b10);
        check_flags("net_at_full", 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);

        // New overflow wins over a same-cycle clr_err.
        pressure_in = 2'b10;
        repeat (5) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_beats_clr_err", 32'(err_ovf), 32'd1);
        pressure_in = '0;
        repeat (6) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Two simultaneous exits at zero.
        do_clr();
        press(2'b00, 2'b11);
        check_flags("underflow", 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("unf_clear", 32'(err_unf), 32'd0);

        // Reach 5, then clr in the cycle the entry event would land.
        press(2'b11, 2'b00);
        press(2'b11, 2'b00);
        press(2'b01, 2'b00);
        check("five", 32'(count), 32'd5);
        pressure_in = 2'b01;
        repeat (5) tick();
        check("before_clr", 32'(count), 32'd5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_flags("clr_vs_event", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        pressure_in = '0;
        repeat (8) tick();
        check("clr_discards", 32'(count), 32'd0);

        // Reset mid-debounce with the pad held across release.
        press(2'b11, 2'b00);
        check("pre_reset", 32'(count), 32'd2);
        pressure_in = 2'b10;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check_flags("async_reset", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_through_reset", 32'(count), 32'd0);
        end
        tick();
        check("held_counts", 32'(count), 32'd1);
        repeat (6) tick();
        pressure_in = '0;
        repeat (8) tick();
        check("held_once", 32'(count), 32'd1);

`ifdef OCC_PEAK_EN
        do_clr();
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        check("peak_cleared", 32'(peak), 32'd0);
        press(2'b11, 2'b00);
        press(2'b11, 2'b00);
        press(2'b11, 2'b00);
        press(2'b01, 2'b00);
        press(2'b00, 2'b11);
        press(2'b00, 2'b11);
        check("peak_count", 32'(count), 32'd3);
        check("peak_hold", 32'(peak), 32'd7);
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        check("peak_reload", 32'(peak), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
